// File: rtl/ms_timer_pkg.sv
// Shared timing definitions for the millisecond counter and the countdown timer.
package ms_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // One tick definition for the whole timing subsystem.
  localparam int unsigned CLK_PER_MS_DEFAULT = 50000;

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk into 1 ms ticks; counts only while enabled, clear has priority.
module ms_prescaler
  import ms_timer_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);

  logic [PRE_W-1:0] pre;

  // Tick is qualified by en so it only fires on a counting edge.
  assign tick = en && (pre == PRE_MAX) && !clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/ms_timer.sv
// Programmable millisecond countdown timer with one-shot and auto-reload modes.
module ms_timer
  import ms_timer_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EXP_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic [EXP_W-1:0] expire_cnt
);

  timer_state_t     state, state_d;
  logic [CNT_W-1:0] reload, reload_d, remaining_d;
  logic             mode, mode_d, expired_d;
  logic [EXP_W-1:0] expire_cnt_d;
  logic             pre_en, pre_clr, tick;

  assign pre_en  = (state == RUN);
  assign pre_clr = start | stop;

  ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Next-state: stop beats start, start beats a coincident expiry tick.
  always_comb begin
    state_d      = state;
    reload_d     = reload;
    mode_d       = mode;
    remaining_d  = remaining;
    expired_d    = 1'b0;
    expire_cnt_d = expire_cnt;

    if (stop) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      if (load_val != '0) begin
        state_d     = RUN;
        remaining_d = load_val;
        reload_d    = load_val;
        mode_d      = periodic;
      end else begin
        // Zero-length load expires immediately and never enters RUN.
        state_d      = IDLE;
        remaining_d  = '0;
        reload_d     = '0;
        mode_d       = 1'b0;
        expired_d    = 1'b1;
        expire_cnt_d = expire_cnt + EXP_W'(1);
      end
    end else if (state == RUN && tick) begin
      if (remaining <= CNT_W'(1)) begin
        expired_d    = 1'b1;
        expire_cnt_d = expire_cnt + EXP_W'(1);
        if (mode) begin
          remaining_d = reload;
        end else begin
          remaining_d = '0;
          state_d     = IDLE;
        end
      end else begin
        remaining_d = remaining - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      reload     <= '0;
      mode       <= 1'b0;
      remaining  <= '0;
      busy       <= 1'b0;
      expired    <= 1'b0;
      expire_cnt <= '0;
    end else begin
      state      <= state_d;
      reload     <= reload_d;
      mode       <= mode_d;
      remaining  <= remaining_d;
      busy       <= (state_d == RUN);
      expired    <= expired_d;
      expire_cnt <= expire_cnt_d;
    end
  end

endmodule

// File: tb/tb_ms_timer.sv
// Self-checking bench for ms_timer against an arithmetic model of the countdown.
module tb_ms_timer;

  localparam int unsigned P     = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned EXP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             periodic = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             expired;
  logic [EXP_W-1:0] expire_cnt;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  ms_timer #(
    .CLK_PER_MS(P),
    .CNT_W     (CNT_W),
    .EXP_W     (EXP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_val  (load_val),
    .remaining (remaining),
    .busy      (busy),
    .expired   (expired),
    .expire_cnt(expire_cnt)
  );

  // Model: k = clock edges elapsed since the start edge (k=0 is the start edge itself).
  function automatic int exp_rem(input int n, input int per, input int k);
    if (per != 0) return n - ((k / P) % n);
    return (k >= n * P) ? 0 : n - (k / P);
  endfunction

  function automatic bit exp_pulse(input int n, input int per, input int k);
    if (k == 0) return 1'b0;
    return (per != 0) ? ((k % (n * P)) == 0) : (k == n * P);
  endfunction

  function automatic bit exp_busy(input int n, input int per, input int k);
    return (per != 0) ? 1'b1 : (k < n * P);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input int per);
    start    = 1'b1;
    load_val = CNT_W'(n);
    periodic = per[0];
    step();
    start    = 1'b0;
    periodic = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (remaining !== '0 || busy !== 1'b0 || expired !== 1'b0 || expire_cnt !== '0) begin
      errors++; $display("FAIL reset_init rem=%0d busy=%b exp=%b cnt=%0d, required all 0", remaining, busy, expired, expire_cnt);
    end
    reset = 1'b1;
    step();
    do_start(5, 0);
    step();
    step();
    checks++; if (remaining !== CNT_W'(5) || busy !== 1'b1) begin
      errors++; $display("FAIL reset_prerun rem=%0d busy=%b, required 5/1", remaining, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (remaining !== '0 || busy !== 1'b0 || expired !== 1'b0 || expire_cnt !== '0) begin
      errors++; $display("FAIL reset_async rem=%0d busy=%b exp=%b cnt=%0d, required all 0", remaining, busy, expired, expire_cnt);
    end
    step();
    reset = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (busy !== 1'b0 || remaining !== '0 || expired !== 1'b0) begin
        errors++; $display("FAIL reset_idle i=%0d busy=%b rem=%0d exp=%b, required 0/0/0", i, busy, remaining, expired);
      end
    end
  endtask

  task automatic test_one_shot();
    do_start(3, 0);
    for (int k = 0; k <= 16; k++) begin
      if (exp_pulse(3, 0, k)) model_cnt++;
      checks++; if (remaining !== CNT_W'(exp_rem(3, 0, k))) begin
        errors++; $display("FAIL one_shot_rem k=%0d got %0d want %0d", k, remaining, exp_rem(3, 0, k));
      end
      checks++; if (busy !== exp_busy(3, 0, k) || expired !== exp_pulse(3, 0, k)) begin
        errors++; $display("FAIL one_shot_flags k=%0d busy=%b exp=%b want %b/%b", k, busy, expired, exp_busy(3, 0, k), exp_pulse(3, 0, k));
      end
      checks++; if (expire_cnt !== EXP_W'(model_cnt)) begin
        errors++; $display("FAIL one_shot_cnt k=%0d got %0d want %0d", k, expire_cnt, EXP_W'(model_cnt));
      end
      step();
    end
  endtask

  task automatic test_periodic();
    do_start(2, 1);
    for (int k = 0; k <= 15 * 8; k++) begin
      if (exp_pulse(2, 1, k)) model_cnt++;
      checks++; if (remaining !== CNT_W'(exp_rem(2, 1, k)) || busy !== 1'b1 || expired !== exp_pulse(2, 1, k)) begin
        errors++; $display("FAIL periodic k=%0d rem=%0d busy=%b exp=%b want %0d/1/%b", k, remaining, busy, expired, exp_rem(2, 1, k), exp_pulse(2, 1, k));
      end
      checks++; if (expire_cnt !== EXP_W'(model_cnt)) begin
        errors++; $display("FAIL periodic_cnt k=%0d got %0d want %0d", k, expire_cnt, EXP_W'(model_cnt));
      end
      step();
    end
    // 1 one-shot expiry + 15 periodic expiries = 16, so the 4-bit count has wrapped.
    checks++; if (expire_cnt !== 4'd0) begin
      errors++; $display("FAIL periodic_wrap got %0d want 0", expire_cnt);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || remaining !== '0 || expired !== 1'b0) begin
      errors++; $display("FAIL periodic_stop busy=%b rem=%0d exp=%b want 0/0/0", busy, remaining, expired);
    end
  endtask

  task automatic test_zero_load();
    do_start(0, 1);
    model_cnt++;
    checks++; if (expired !== 1'b1 || busy !== 1'b0 || remaining !== '0 || expire_cnt !== EXP_W'(model_cnt)) begin
      errors++; $display("FAIL zero_pulse exp=%b busy=%b rem=%0d cnt=%0d want 1/0/0/%0d", expired, busy, remaining, expire_cnt, EXP_W'(model_cnt));
    end
    for (int i = 1; i <= 50; i++) begin
      step();
      checks++; if (expired !== 1'b0 || busy !== 1'b0 || expire_cnt !== EXP_W'(model_cnt)) begin
        errors++; $display("FAIL zero_quiet i=%0d exp=%b busy=%b cnt=%0d want 0/0/%0d", i, expired, busy, expire_cnt, EXP_W'(model_cnt));
      end
    end
  endtask

  task automatic test_collisions();
    // Restart lands exactly on the one-shot expiry edge (k=8 for load 2).
    do_start(2, 0);
    for (int k = 1; k < 8; k++) step();
    do_start(5, 0);
    checks++; if (expired !== 1'b0 || remaining !== CNT_W'(5) || busy !== 1'b1 || expire_cnt !== EXP_W'(model_cnt)) begin
      errors++; $display("FAIL restart_at_expiry exp=%b rem=%0d busy=%b cnt=%0d want 0/5/1/%0d", expired, remaining, busy, expire_cnt, EXP_W'(model_cnt));
    end
    for (int k = 1; k <= 22; k++) begin
      step();
      if (exp_pulse(5, 0, k)) model_cnt++;
      checks++; if (remaining !== CNT_W'(exp_rem(5, 0, k)) || expired !== exp_pulse(5, 0, k) || expire_cnt !== EXP_W'(model_cnt)) begin
        errors++; $display("FAIL restart_run k=%0d rem=%0d exp=%b cnt=%0d want %0d/%b/%0d", k, remaining, expired, expire_cnt, exp_rem(5, 0, k), exp_pulse(5, 0, k), EXP_W'(model_cnt));
      end
    end
    // Start and stop together while running: stop wins.
    do_start(4, 1);
    step();
    start = 1'b1; stop = 1'b1; load_val = CNT_W'(7);
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || remaining !== '0 || expired !== 1'b0) begin
      errors++; $display("FAIL start_stop busy=%b rem=%0d exp=%b want 0/0/0", busy, remaining, expired);
    end
    // Stop at E0+6 of a load-3 one-shot: no expiry ever.
    do_start(3, 0);
    for (int k = 1; k < 6; k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (expired !== 1'b0 || busy !== 1'b0 || remaining !== '0 || expire_cnt !== EXP_W'(model_cnt)) begin
        errors++; $display("FAIL stop_abort i=%0d exp=%b busy=%b rem=%0d cnt=%0d want 0/0/0/%0d", i, expired, busy, remaining, expire_cnt, EXP_W'(model_cnt));
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n, per, len;
      n   = int'($urandom_range(1, 5));
      per = int'($urandom_range(0, 1));
      len = int'($urandom_range(5, 2 * n * P + 6));
      do_start(n, per);
      for (int k = 0; k < len; k++) begin
        if (k > 0) step();
        if (exp_pulse(n, per, k)) model_cnt++;
        checks++; if (remaining !== CNT_W'(exp_rem(n, per, k)) || busy !== exp_busy(n, per, k) || expired !== exp_pulse(n, per, k)) begin
          errors++; $display("FAIL random it=%0d n=%0d per=%0d k=%0d rem=%0d busy=%b exp=%b want %0d/%b/%b", it, n, per, k, remaining, busy, expired, exp_rem(n, per, k), exp_busy(n, per, k), exp_pulse(n, per, k));
        end
        checks++; if (expire_cnt !== EXP_W'(model_cnt)) begin
          errors++; $display("FAIL random_cnt it=%0d k=%0d got %0d want %0d", it, k, expire_cnt, EXP_W'(model_cnt));
        end
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || remaining !== '0 || expired !== 1'b0) begin
      errors++; $display("FAIL random_stop busy=%b rem=%0d exp=%b want 0/0/0", busy, remaining, expired);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_zero_load();
    test_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ms_timer.md
Name: ms_timer

Overview:
- Programmable millisecond countdown timer; the consumer/alarm side of the free-running millisecond count.
- Divides clk into 1 ms ticks, counts a loaded value down to zero, and raises a one-cycle expiry pulse.
- Supports one-shot and periodic (auto-reload) modes.
- Sits beside the millisecond counter in the timing subsystem and feeds interrupt/sequencer logic.

Parameters:
- CLK_PER_MS, 50000, clk cycles per millisecond tick (≥2).
- CNT_W, 32, width of load value and remaining count.
- EXP_W, 16, width of the expiry event counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  pulse; load load_val and begin countdown.
- stop  in  1  pulse; abort countdown, return to IDLE.
- periodic  in  1  sampled with start; 1 = auto-reload on expiry.
- load_val  in  CNT_W  countdown length in ms; sampled with start.
- remaining  out  CNT_W  ms left in the current period.
- busy  out  1  1 while in RUN.
- expired  out  1  one-cycle pulse on reaching zero.
- expire_cnt  out  EXP_W  number of expiries since reset; wraps modulo 2^EXP_W.

Behaviour:
- Reset (reset=0, async) sets:
  - FSM=IDLE; remaining=0; busy=0; expired=0; expire_cnt=0.
  - Prescaler=0; reload register=0; mode register=0.
- FSM has two states: IDLE and RUN. busy = (state==RUN), registered.
- Prescaler:
  - Counts 0..CLK_PER_MS-1 only in RUN. tick = (pre==CLK_PER_MS-1) at a RUN edge; pre then wraps to 0.
  - Cleared to 0 by any accepted start and by stop.
- Start at edge E0, with stop=0 and load_val=N>0:
  - remaining=N, reload=N, mode=periodic, pre=0, state=RUN.
  - The first ms is a full CLK_PER_MS cycles.
- Decrement: on a tick in RUN, remaining decrements by 1.
  - Decrements occur at edges E0+P, E0+2P, …, where P=CLK_PER_MS.
- Expiry (the tick where remaining==1):
  - expired=1 for exactly the one cycle after edge E0+N·P; expire_cnt increments at that same edge.
  - One-shot: remaining=0, state=IDLE, busy=0 at that edge.
  - Periodic: remaining=reload, state stays RUN. The next expiry follows N·P cycles later with no gap or extra cycle.
- Start with load_val=0: no RUN entry.
  - expired pulses the cycle after E0; expire_cnt increments; remaining stays 0; busy stays 0.
  - Periodic is ignored for a zero load (no continuous pulsing).
- Start while RUN: restart. Reload, mode, remaining and pre are reloaded as above; no expiry is generated for the aborted period.
- Stop (any state): state=IDLE, remaining=0, pre=0, no expired pulse.
- Start and stop in the same cycle: stop wins; start is ignored.
- Start coinciding with the expiry tick: the restart wins and no expired pulse is generated for that tick.
- remaining never underflows below 0. expire_cnt wraps from all-ones to 0 silently.
- Inputs are synchronous to clk; no internal synchronisers.
- Outputs are all registered; no combinational paths from inputs to outputs.

Decomposition:
- Shared timer package holds:
  - typedef enum logic {IDLE, RUN} timer_state_t.
  - Default CLK_PER_MS constant, shared with the millisecond counter so both use one tick definition.
- One natural sub-module: ms_prescaler (inputs clk, reset, en, clr; output tick). Holds the 0..CLK_PER_MS-1 counter, width $clog2(CLK_PER_MS).
- The FSM, remaining/reload registers and expire_cnt live in ms_timer.

Test Plan:
- Bench parameters: CLK_PER_MS=4, CNT_W=32, EXP_W=4.
- Reset: drive reset=0 mid-RUN (remaining=5) → all outputs 0 immediately, asynchronously. Release → stays IDLE until start.
- One-shot: start, load_val=3, periodic=0 at E0 → remaining 3,2,1,0 at E0+1/4/8/12; expired high only the cycle after E0+12; busy falls at E0+12; expire_cnt=1.
- Periodic: load_val=2, periodic=1 → expired pulses after E0+8, E0+16, E0+24; busy stays 1; remaining reloads to 2. After 16 expiries, expire_cnt wraps to 0.
- Zero load: start, load_val=0, periodic=1 → single expired pulse the cycle after E0; busy never rises; no further pulses over 50 cycles.
- Restart/stop collisions:
  - Start(load 5) at the expiry edge of a one-shot → no expired pulse; remaining=5.
  - Start and stop in the same cycle during RUN → IDLE, remaining=0.
  - Stop at E0+6 of load 3 → no expiry ever.
